uart_mmio_tx: RTL and testbench

- Memory-mapped, transmit-only UART peripheral on the CPU native memory bus.
- Occupies the 4 KB window at 0x8000_0000. The top level gates mem_valid by address decode; the block decodes only mem_addr[3:2].
- Serialises bytes written by firmware as 8N1 frames on uart_tx, with a status register for polling.

---
 rtl/uart_mmio_tx_if.sv | 19 +
 rtl/uart_mmio_tx.sv | 210 +++++++++++++++++++++
 tb/tb_uart_mmio_tx.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_tx_if.sv
// Native memory-bus bundle between the CPU side (master) and the UART transmitter (slave).
interface uart_mmio_tx_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/uart_mmio_tx.sv
// Memory-mapped transmit-only 8N1 UART with TXDATA/STATUS/BAUDDIV registers.
// Define UART_TX_FIFO_EN to queue bytes in a FIFO_DEPTH FIFO instead of a single holding register.
module uart_mmio_tx #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    uart_mmio_tx_if.slave bus,
    output logic          uart_tx
);
    localparam logic [15:0] DIV_RESET = 16'(CLOCK_FREQ / BAUD_RATE);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
    typedef enum logic [1:0] {
        REG_TXDATA  = 2'd0,
        REG_STATUS  = 2'd1,
        REG_BAUDDIV = 2'd2,
        REG_RSVD    = 2'd3
    } reg_sel_e;

    reg_sel_e    reg_sel;
    logic        accept, wr_en, rd_en;
    logic        push_req, push, pop;
    logic        q_full, q_empty;
    logic [7:0]  q_data;
    logic        ready_q;
    logic [31:0] rdata_q, read_value;
    logic [15:0] baud_div;
    logic        overflow;
    logic        busy;

    tx_state_e   state, state_next;
    logic [15:0] baud_cnt, frame_div;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        tx_q, tx_next, shift, bit_done;

    assign reg_sel  = reg_sel_e'(bus.mem_addr[3:2]);
    assign accept   = bus.mem_valid && !ready_q;
    assign wr_en    = accept && (bus.mem_wstrb != 4'b0000);
    assign rd_en    = accept && (bus.mem_wstrb == 4'b0000);
    // Full is sampled before this cycle's pop, so a write racing a pop into a full queue is dropped.
    assign push_req = wr_en && (reg_sel == REG_TXDATA) && bus.mem_wstrb[0];
    assign push     = push_req && !q_full;

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign uart_tx       = tx_q;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    // Extra pointer bit separates full from empty when the index bits match.
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign q_data  = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.mem_wdata[7:0];
    end
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic       hold_valid;
    logic [7:0] hold_data;

    assign q_empty = !hold_valid;
    assign q_full  = hold_valid;
    assign q_data  = hold_data;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)    hold_valid <= 1'b0;
        else if (push) hold_valid <= 1'b1;
        else if (pop)  hold_valid <= 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (push) hold_data <= bus.mem_wdata[7:0];
    end
`endif

    assign busy = (state != ST_IDLE) || !q_empty;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        read_value = '0;
        case (reg_sel)
            REG_STATUS:  read_value = {28'd0, !busy, overflow, q_full, busy};
            REG_BAUDDIV: read_value = {16'd0, baud_div};
            default:     read_value = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            baud_div <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            ready_q <= accept;
            rdata_q <= rd_en ? read_value : '0;
            if (wr_en && (reg_sel == REG_BAUDDIV) && (|bus.mem_wstrb[1:0]))
                baud_div <= (bus.mem_wdata[15:0] == 16'd0) ? 16'd1 : bus.mem_wdata[15:0];
            if (push_req && q_full)
                overflow <= 1'b1;
            else if (wr_en && (reg_sel == REG_STATUS) && bus.mem_wdata[2])
                overflow <= 1'b0;
        end
    end

    assign bit_done = (baud_cnt == 16'd0);

    always_comb begin
        state_next = state;
        tx_next    = tx_q;
        pop        = 1'b0;
        shift      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                    tx_next    = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next = shreg[1];
                    end
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when another byte is waiting.
                if (bit_done) begin
                    if (!q_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tx_q      <= 1'b1;
            baud_cnt  <= '0;
            frame_div <= DIV_RESET;
            bit_cnt   <= '0;
            shreg     <= '0;
        end else begin
            state <= state_next;
            tx_q  <= tx_next;
            if (pop) begin
                // The divisor is latched per frame so mid-frame BAUDDIV writes wait for the next start.
                shreg     <= q_data;
                frame_div <= baud_div;
                baud_cnt  <= baud_div - 16'd1;
                bit_cnt   <= '0;
            end else if (state != ST_IDLE) begin
                if (bit_done) begin
                    baud_cnt <= frame_div - 16'd1;
                    if (shift) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt - 16'd1;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.mem_addr[31:4], bus.mem_addr[1:0], bus.mem_wdata[31:16]};
endmodule

// File: tb/tb_uart_mmio_tx.sv
// Self-checking bench for uart_mmio_tx: bus tasks drive registers, a line monitor decodes
// frames cycle by cycle and compares them against a queue of expected bytes.
module tb_uart_mmio_tx;
    localparam logic [31:0] A_TX = 32'h8000_0000;
    localparam logic [31:0] A_ST = 32'h8000_0004;
    localparam logic [31:0] A_BD = 32'h8000_0008;
    localparam logic [31:0] A_RS = 32'h8000_000C;
`ifdef UART_TX_FIFO_EN
    localparam int OUTSTANDING = 17;
    localparam int B2B_N       = 3;
`else
    localparam int OUTSTANDING = 2;
    localparam int B2B_N       = 2;
`endif

    logic sys_clk;
    logic rst_n;
    logic uart_tx;

    uart_mmio_tx_if bus ();

    uart_mmio_tx dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_acc = 0;
    int         model_div = 1085;
    int         frames_started = 0;
    int         frames_done = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc++;

    // Decode one frame starting at the negedge where the start bit was first seen.
    task automatic rx_frame();
        int         div;
        logic [9:0] pat;
        logic [7:0] exp_b;
        logic [7:0] got;
        bit         have_exp, bad, aborted;
        div = model_div;
        frames_started++;
        start_q.push_back(cyc);
        have_exp = (exp_q.size() > 0);
        exp_b    = have_exp ? exp_q.pop_front() : 8'h00;
        pat      = {1'b1, exp_b, 1'b0};
        got      = '0;
        bad      = 1'b0;
        aborted  = 1'b0;
        for (int k = 0; k < 10 * div; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (!rst_n) begin
                aborted = 1'b1;
                break;
            end
            if ((k / div) >= 1 && (k / div) <= 8 && (k % div) == div / 2) got[k / div - 1] = uart_tx;
            if (uart_tx !== pat[k / div]) bad = 1'b1;
        end
        if (!aborted) begin
            n_checks++;
            if (!have_exp) begin
                n_errors++;
                $display("FAIL frame_unexpected: got byte %02h, expected no frame", got);
            end else if (bad) begin
                n_errors++;
                $display("FAIL frame_bits: got byte %02h, expected %02h (div %0d, cycle %0d)", got, exp_b, div, cyc);
            end
            frames_done++;
        end
    endtask

    initial begin : line_monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (rst_n && prev && !uart_tx) rx_frame();
            prev = uart_tx;
        end
    end

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] rdata, output int lat);
        @(negedge sys_clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (bus.mem_ready !== 1'b1 && lat < 8);
        n_checks++;
        if (bus.mem_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bus_timeout: mem_ready=%b after %0d cycles at addr %08h, expected 1", bus.mem_ready, lat, addr);
        end
        rdata    = bus.mem_rdata;
        last_acc = cyc;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        int          lat;
        bus_xfer(addr, data, 4'hF, rd, lat);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        int lat;
        bus_xfer(addr, 32'h0, 4'h0, data, lat);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        n_checks++;
        if (frames_done < target) begin
            n_errors++;
            $display("FAIL %s: got %0d frames, expected %0d within %0d cycles", name, frames_done, target, budget);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int          seen = 0;
        rst_n = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        n_checks++;
        if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_bus: got ready=%b rdata=%08h expected 0/0", bus.mem_ready, bus.mem_rdata);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge sys_clk);
            if (bus.mem_ready !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL idle_ready: got %0d ready cycles expected 0", seen); end
        bus_read(A_ST, rd);
        n_checks++;
        if (rd !== 32'h8) begin n_errors++; $display("FAIL reset_status: got %08h expected 00000008", rd); end
        bus_read(A_BD, rd);
        n_checks++;
        if (rd !== 32'd1085) begin n_errors++; $display("FAIL reset_bauddiv: got %0d expected 1085", rd); end
        bus_read(A_RS, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL read_rsvd: got %08h expected 0", rd); end
        bus_read(A_TX, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL read_txdata: got %08h expected 0", rd); end
        bus_read(32'h8000_0014, rd);
        n_checks++;
        if (rd !== 32'h8) begin n_errors++; $display("FAIL status_alias: got %08h expected 00000008", rd); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        int          lat, acc, fd0, s0;
        fd0 = frames_done;
        s0  = start_q.size();
        exp_q.push_back(8'h55);
        bus_xfer(A_TX, 32'h55, 4'hF, rd, lat);
        acc = last_acc;
        n_checks++;
        if (lat != 1) begin n_errors++; $display("FAIL write_latency: got %0d expected 1", lat); end
        @(negedge sys_clk);
        n_checks++;
        if (bus.mem_ready !== 1'b0) begin n_errors++; $display("FAIL ready_pulse: got %b expected 0", bus.mem_ready); end
        bus_read(A_ST, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL status_busy: got %08h expected 00000001", rd); end
        wait_frames(fd0 + 1, 11500, "frame_55");
        n_checks++;
        if (start_q.size() <= s0 || start_q[s0] - acc < 1 || start_q[s0] - acc > 2) begin
            n_errors++; $display("FAIL start_latency: got %0d start(s), first at +%0d, expected +1..2",
                                 start_q.size() - s0, (start_q.size() > s0) ? start_q[s0] - acc : -1);
        end
        bus_read(A_ST, rd);
        n_checks++;
        if (rd !== 32'h8) begin n_errors++; $display("FAIL status_idle: got %08h expected 00000008", rd); end
    endtask

    task automatic test_baud_div();
        logic [31:0] rd;
        int          fd0;
        bus_write(A_BD, 32'd4);
        model_div = 4;
        bus_read(A_BD, rd);
        n_checks++;
        if (rd !== 32'h4) begin n_errors++; $display("FAIL bauddiv_rw: got %08h expected 00000004", rd); end
        fd0 = frames_done;
        exp_q.push_back(8'hA3);
        bus_write(A_TX, 32'hA3);
        wait_frames(fd0 + 1, 100, "frame_a3");
        bus_write(A_BD, 32'd0);
        bus_read(A_BD, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL bauddiv_zero: got %08h expected 00000001", rd); end
        bus_write(A_BD, 32'd4);
        model_div = 4;
    endtask

    task automatic test_back_to_back();
        int fd0, s0, gap;
        fd0 = frames_done;
        s0  = start_q.size();
        for (int i = 0; i < B2B_N; i++) begin
            exp_q.push_back(8'(i + 1));
            bus_write(A_TX, 32'(i + 1));
        end
        wait_frames(fd0 + B2B_N, 40 * B2B_N + 100, "b2b_frames");
        for (int i = 1; i < B2B_N; i++) begin
            gap = (start_q.size() > s0 + i) ? start_q[s0 + i] - start_q[s0 + i - 1] : -1;
            n_checks++;
            if (gap != 40) begin n_errors++; $display("FAIL b2b_gap%0d: got %0d cycles expected 40", i, gap); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        int          fd0, fs0;
        bus_write(A_BD, 32'd1085);
        model_div = 1085;
        fd0 = frames_done;
        fs0 = frames_started;
        for (int i = 0; i <= OUTSTANDING; i++) begin
            if (i < OUTSTANDING) exp_q.push_back(8'(8'h30 + i));
            bus_write(A_TX, 32'(8'h30 + i));
        end
        bus_read(A_ST, rd);
        n_checks++;
        if (rd !== 32'h7) begin n_errors++; $display("FAIL status_overflow: got %08h expected 00000007", rd); end
        bus_write(A_ST, 32'h4);
        bus_read(A_ST, rd);
        n_checks++;
        if (rd !== 32'h3) begin n_errors++; $display("FAIL overflow_clear: got %08h expected 00000003", rd); end
        bus_write(A_BD, 32'd4);
        model_div = 4;
        wait_frames(fd0 + OUTSTANDING, 10850 + 40 * OUTSTANDING + 500, "overflow_frames");
        repeat (100) @(negedge sys_clk);
        n_checks++;
        if (frames_started - fs0 != OUTSTANDING) begin
            n_errors++; $display("FAIL overflow_count: got %0d frames expected %0d", frames_started - fs0, OUTSTANDING);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int          fs0;
        bus_write(A_BD, 32'd1085);
        model_div = 1085;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h00);
        repeat (3000) @(negedge sys_clk);
        n_checks++;
        if (uart_tx !== 1'b0) begin n_errors++; $display("FAIL midframe_pre: got %b expected 0", uart_tx); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL async_reset_tx: got %b expected 1", uart_tx); end
        exp_q.delete();
        model_div = 1085;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        fs0 = frames_started;
        bus_read(A_ST, rd);
        n_checks++;
        if (rd !== 32'h8) begin n_errors++; $display("FAIL post_reset_status: got %08h expected 00000008", rd); end
        repeat (300) @(negedge sys_clk);
        n_checks++;
        if (frames_started != fs0) begin
            n_errors++; $display("FAIL post_reset_frames: got %0d frames expected 0", frames_started - fs0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_frame();
        test_baud_div();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
